vertex_buffer_xn: RTL and testbench

VERTEX_BUFFER_XN -- requirements
Module: vertex_buffer_xn

---
 rtl/vbuf_pkg.sv | 22 ++
 rtl/vertex_buffer_xn_bank.sv | 32 +++
 rtl/vertex_buffer_xn_rr_arbiter.sv | 51 +++++
 rtl/vertex_buffer_xn.sv | 199 +++++++++++++++++++
 tb/tb_vertex_buffer_xn.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vbuf_pkg.sv
// Shared types and constants for the banked vertex buffer.
package vbuf_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_BANK_NUM_W = 5;
    localparam int DEF_PORT_NUM   = 8;

    localparam int BANKS = 2 ** DEF_BANK_NUM_W;
    localparam int ROW_W = DEF_ADDR_W - DEF_BANK_NUM_W;

    typedef enum logic {
        IDLE,
        INIT
    } vbuf_state_t;

    // Pointer width for a round-robin over n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vertex_buffer_xn_bank.sv
// One storage bank: one synchronous write and one synchronous read per cycle.
// A read and a write to the same row in the same cycle return the old contents.
module vbuf_bank #(
    parameter int DATA_W = vbuf_pkg::DEF_DATA_W,
    parameter int ROW_W  = vbuf_pkg::ROW_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ROW_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ROW_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ROW_W];

    // Write port: contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered data, held when no read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vertex_buffer_xn_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner and stays put when nobody asks.
module rr_arbiter
    import vbuf_pkg::*;
#(
    parameter int PORT_NUM = DEF_PORT_NUM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] req,
    output logic [PORT_NUM-1:0] grant
);

    localparam int PTR_W = ptr_width(PORT_NUM);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] idx_p;
    logic             any;

    // Search circularly from the pointer for the first active request.
    always_comb begin
        int idx;
        idx      = 0;
        idx_p    = '0;
        grant    = '0;
        winner   = ptr;
        any      = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            idx   = (int'(ptr) + i) % PORT_NUM;
            idx_p = PTR_W'(idx);
            if (!any && req[idx_p]) begin
                grant[idx_p] = 1'b1;
                winner       = idx_p;
                any          = 1'b1;
            end
        end
        ptr_next = (int'(winner) == PORT_NUM - 1) ? '0 : winner + PTR_W'(1);
    end

    // Advance the pointer only when a grant was issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/vertex_buffer_xn.sv
// Multi-ported banked vertex buffer: independent per-bank read and write
// round-robin arbitration, two-cycle read latency, and an init sweep that
// fills every row of every bank with INIT_VAL.
module vertex_buffer_xn
    import vbuf_pkg::*;
#(
    parameter int              DATA_W     = DEF_DATA_W,
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              BANK_NUM_W = DEF_BANK_NUM_W,
    parameter int              PORT_NUM   = DEF_PORT_NUM,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_start,
    output logic                         busy,
    input  logic [PORT_NUM*ADDR_W-1:0]   R_Addr,
    input  logic [PORT_NUM-1:0]          R_valid,
    output logic [PORT_NUM-1:0]          R_ready,
    input  logic [PORT_NUM*ADDR_W-1:0]   W_Addr,
    input  logic [PORT_NUM*DATA_W-1:0]   W_Data,
    input  logic [PORT_NUM-1:0]          W_valid,
    output logic [PORT_NUM-1:0]          W_ready,
    output logic [PORT_NUM-1:0]          R_out_valid,
    output logic [PORT_NUM*DATA_W-1:0]   R_Data
);

    localparam int NUM_BANKS = 2 ** BANK_NUM_W;
    localparam int ROW_BITS  = ADDR_W - BANK_NUM_W;

    vbuf_state_t          state;
    logic [ROW_BITS-1:0]  row_cnt;
    logic                 accepting;

    logic [BANK_NUM_W-1:0] r_bank [PORT_NUM];
    logic [ROW_BITS-1:0]   r_row  [PORT_NUM];
    logic [BANK_NUM_W-1:0] w_bank [PORT_NUM];
    logic [ROW_BITS-1:0]   w_row  [PORT_NUM];
    logic [DATA_W-1:0]     w_dat  [PORT_NUM];

    logic [PORT_NUM-1:0] rd_req [NUM_BANKS];
    logic [PORT_NUM-1:0] rd_gnt [NUM_BANKS];
    logic [PORT_NUM-1:0] wr_req [NUM_BANKS];
    logic [PORT_NUM-1:0] wr_gnt [NUM_BANKS];

    logic                bank_re    [NUM_BANKS];
    logic [ROW_BITS-1:0] bank_raddr [NUM_BANKS];
    logic                bank_we    [NUM_BANKS];
    logic [ROW_BITS-1:0] bank_waddr [NUM_BANKS];
    logic [DATA_W-1:0]   bank_wdata [NUM_BANKS];
    logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];

    logic [PORT_NUM-1:0]   s1_valid;
    logic [BANK_NUM_W-1:0] s1_bank [PORT_NUM];

    assign accepting = (state == IDLE);

    // Split each port's address into bank select (low bits) and row.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            r_bank[p] = R_Addr[p*ADDR_W +: BANK_NUM_W];
            r_row[p]  = R_Addr[p*ADDR_W + BANK_NUM_W +: ROW_BITS];
            w_bank[p] = W_Addr[p*ADDR_W +: BANK_NUM_W];
            w_row[p]  = W_Addr[p*ADDR_W + BANK_NUM_W +: ROW_BITS];
            w_dat[p]  = W_Data[p*DATA_W +: DATA_W];
        end
    end

    // Route each port's request to its bank; nothing is requested during the sweep.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                rd_req[b][p] = accepting && R_valid[p] && (int'(r_bank[p]) == b);
                wr_req[b][p] = accepting && W_valid[p] && (int'(w_bank[p]) == b);
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.PORT_NUM(PORT_NUM)) u_rd_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (rd_req[b]),
            .grant (rd_gnt[b])
        );

        rr_arbiter #(.PORT_NUM(PORT_NUM)) u_wr_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (wr_req[b]),
            .grant (wr_gnt[b])
        );

        vbuf_bank #(.DATA_W(DATA_W), .ROW_W(ROW_BITS)) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr[b]),
            .wdata (bank_wdata[b]),
            .re    (bank_re[b]),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    // Steer the winning port onto each bank; the sweep owns every write port while busy.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_re[b]    = |rd_gnt[b];
            bank_raddr[b] = '0;
            bank_we[b]    = (state == INIT) || (|wr_gnt[b]);
            bank_waddr[b] = row_cnt;
            bank_wdata[b] = INIT_VAL;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (rd_gnt[b][p]) begin
                    bank_raddr[b] = r_row[p];
                end
                if (wr_gnt[b][p]) begin
                    bank_waddr[b] = w_row[p];
                    bank_wdata[b] = w_dat[p];
                end
            end
        end
    end

    // A port is ready when it wins the bank its address selects.
    always_comb begin
        R_ready = '0;
        W_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            R_ready = R_ready | rd_gnt[b];
            W_ready = W_ready | wr_gnt[b];
        end
    end

    // Stage 1: remember which bank each accepted read went to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                s1_bank[p] <= '0;
            end
        end else begin
            s1_valid <= R_ready;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (R_ready[p]) begin
                    s1_bank[p] <= r_bank[p];
                end
            end
        end
    end

    // Stage 2: register the bank output per port; data holds between valid pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            R_out_valid <= '0;
            R_Data      <= '0;
        end else begin
            R_out_valid <= s1_valid;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (s1_valid[p]) begin
                    R_Data[p*DATA_W +: DATA_W] <= bank_rdata[s1_bank[p]];
                end
            end
        end
    end

    // Init sweep control: one row per cycle across all banks, busy registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            row_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state   <= INIT;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                INIT: begin
                    if (row_cnt == '1) begin
                        state   <= IDLE;
                        row_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        row_cnt <= row_cnt + ROW_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_buffer_xn.sv
// Testbench for vertex_buffer_xn: table-driven arbitration vectors plus
// hand-written multi-cycle sequences, with a per-port read scoreboard.
module tb_vertex_buffer_xn;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int BANK_NUM_W = 2;
    localparam int PORT_NUM   = 4;
    localparam logic [31:0] INIT_VAL = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init_start = 1'b0;
    logic         busy;
    logic [31:0]  R_Addr = '0;
    logic [3:0]   R_valid = '0;
    logic [3:0]   R_ready;
    logic [31:0]  W_Addr = '0;
    logic [127:0] W_Data = '0;
    logic [3:0]   W_valid = '0;
    logic [3:0]   W_ready;
    logic [3:0]   R_out_valid;
    logic [127:0] R_Data;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q [PORT_NUM][$];

    typedef struct {
        string          name;
        logic [3:0]     r_valid;
        logic [3:0][7:0] r_addr;
        logic [3:0]     w_valid;
        logic [3:0][7:0] w_addr;
        logic [3:0][31:0] w_data;
        logic [3:0]     exp_r;
        logic [3:0]     exp_w;
    } vec_t;

    vec_t vecs [7];

    vertex_buffer_xn #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BANK_NUM_W (BANK_NUM_W),
        .PORT_NUM   (PORT_NUM),
        .INIT_VAL   (INIT_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_start  (init_start),
        .busy        (busy),
        .R_Addr      (R_Addr),
        .R_valid     (R_valid),
        .R_ready     (R_ready),
        .W_Addr      (W_Addr),
        .W_Data      (W_Data),
        .W_valid     (W_valid),
        .W_ready     (W_ready),
        .R_out_valid (R_out_valid),
        .R_Data      (R_Data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: predicts read data at acceptance, checks it two cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                exp_q[p].delete();
                checkOutput($sformatf("reset_rdata_p%0d", p), R_Data[p*32 +: 32], 32'h0);
            end
            checkOutput("reset_out_valid", 32'(R_out_valid), 32'h0);
            checkOutput("reset_busy", 32'(busy), 32'h0);
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (exp_q[p].size() != 0 && exp_q[p][0].due == cyc) begin
                    checkOutput($sformatf("sb_valid_p%0d", p), 32'(R_out_valid[p]), 32'h1);
                    checkOutput($sformatf("sb_data_p%0d", p), R_Data[p*32 +: 32], exp_q[p][0].data);
                    void'(exp_q[p].pop_front());
                end else begin
                    checkOutput($sformatf("sb_idle_p%0d", p), 32'(R_out_valid[p]), 32'h0);
                end
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                if (R_ready[p]) begin
                    checkOutput($sformatf("rready_has_valid_p%0d", p), 32'(R_valid[p]), 32'h1);
                    exp_q[p].push_back('{data: ref_mem[R_Addr[p*8 +: 8]], due: cyc + 2});
                end
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                if (W_ready[p]) begin
                    checkOutput($sformatf("wready_has_valid_p%0d", p), 32'(W_valid[p]), 32'h1);
                    ref_mem[W_Addr[p*8 +: 8]] = W_Data[p*32 +: 32];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeOne(input int p, input logic [7:0] a, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        W_Addr[p*8 +: 8]   = a;
        W_Data[p*32 +: 32] = d;
        W_valid[p]         = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = W_ready[p];
        end
        checkOutput($sformatf("write_accept_%h", a), 32'(ok), 32'h1);
        tick();
        W_valid[p] = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        R_valid = v.r_valid;
        R_Addr  = v.r_addr;
        W_valid = v.w_valid;
        W_Addr  = v.w_addr;
        W_Data  = v.w_data;
        @(negedge clk);
        checkOutput({v.name, "_rready"}, 32'(R_ready), 32'(v.exp_r));
        checkOutput({v.name, "_wready"}, 32'(W_ready), 32'(v.exp_w));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // Arbitration vectors; pointer history from the earlier sequences is
        // b0=1 b1=2 b2=3 b3=0 for reads and 1 for every write pointer.
        vecs[0] = '{"v0", 4'b0011, {8'h00, 8'h00, 8'h04, 8'h00}, 4'b1100,
                    {8'h09, 8'h05, 8'h00, 8'h00},
                    {32'h9999_0009, 32'h5555_0005, 32'h0, 32'h0}, 4'b0010, 4'b0100};
        vecs[1] = '{"v1", 4'b1001, {8'h08, 8'h00, 8'h00, 8'h00}, 4'b1010,
                    {8'h09, 8'h00, 8'h0D, 8'h00},
                    {32'h9999_0009, 32'h0, 32'hDDDD_000D, 32'h0}, 4'b1000, 4'b1000};
        vecs[2] = '{"v2", 4'b0001, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0010,
                    {8'h00, 8'h00, 8'h0D, 8'h00},
                    {32'h0, 32'h0, 32'hDDDD_000D, 32'h0}, 4'b0001, 4'b0010};
        vecs[3] = '{"v3", 4'b1111, {8'h01, 8'h0D, 8'h09, 8'h05}, 4'b0001,
                    {8'h00, 8'h00, 8'h00, 8'h06},
                    {32'h0, 32'h0, 32'h0, 32'h6666_0006}, 4'b0100, 4'b0001};
        vecs[4] = '{"v4", 4'b1111, {8'h01, 8'h06, 8'h09, 8'h05}, 4'b0000,
                    {8'h00, 8'h00, 8'h00, 8'h00},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b1100, 4'b0000};
        vecs[5] = '{"v5", 4'b0011, {8'h00, 8'h00, 8'h09, 8'h05}, 4'b0000,
                    {8'h00, 8'h00, 8'h00, 8'h00},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 4'b0000};
        vecs[6] = '{"v6", 4'b0010, {8'h00, 8'h00, 8'h09, 8'h00}, 4'b0000,
                    {8'h00, 8'h00, 8'h00, 8'h00},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0010, 4'b0000};

        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        $display("[TB] preload");
        writeOne(0, 8'h00, 32'h1000_0000);
        writeOne(0, 8'h04, 32'h1000_0004);
        writeOne(0, 8'h08, 32'h1000_0008);
        writeOne(0, 8'h0C, 32'h1000_000C);
        writeOne(0, 8'h01, 32'h2000_0001);
        writeOne(0, 8'h02, 32'h2000_0002);
        writeOne(0, 8'h03, 32'h2000_0003);
        writeOne(0, 8'h20, 32'h0000_0003);

        $display("[TB] same-bank round robin");
        R_Addr  = {8'h0C, 8'h08, 8'h04, 8'h00};
        R_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_order_%0d", k), 32'(R_ready), 32'(1) << k);
            tick();
            R_valid[k] = 1'b0;
        end
        R_valid = '0;
        repeat (3) tick();

        $display("[TB] distinct banks in parallel");
        R_Addr  = {8'h03, 8'h02, 8'h01, 8'h00};
        R_valid = 4'b1111;
        @(negedge clk);
        checkOutput("parallel_ready", 32'(R_ready), 32'hF);
        tick();
        R_valid = '0;
        tick();
        @(negedge clk);
        checkOutput("parallel_out_valid", 32'(R_out_valid), 32'hF);
        tick();
        repeat (2) tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
        R_valid = '0;
        W_valid = '0;
        repeat (3) tick();

        $display("[TB] write then read next cycle");
        writeOne(0, 8'h10, 32'hA5A5_0001);
        R_Addr[2*8 +: 8] = 8'h10;
        R_valid[2] = 1'b1;
        @(negedge clk);
        checkOutput("wr_rd_ready", 32'(R_ready[2]), 32'h1);
        tick();
        R_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("wr_rd_t1_valid", 32'(R_out_valid[2]), 32'h0);
        tick();
        @(negedge clk);
        checkOutput("wr_rd_t2_valid", 32'(R_out_valid[2]), 32'h1);
        checkOutput("wr_rd_t2_data", R_Data[2*32 +: 32], 32'hA5A5_0001);
        tick();
        @(negedge clk);
        checkOutput("wr_rd_t3_valid", 32'(R_out_valid[2]), 32'h0);
        checkOutput("wr_rd_t3_hold", R_Data[2*32 +: 32], 32'hA5A5_0001);
        tick();

        $display("[TB] same-cycle read and write");
        R_Addr[0*8 +: 8]   = 8'h20;
        R_valid[0]         = 1'b1;
        W_Addr[1*8 +: 8]   = 8'h20;
        W_Data[1*32 +: 32] = 32'h0000_0005;
        W_valid[1]         = 1'b1;
        @(negedge clk);
        checkOutput("rw_same_rready", 32'(R_ready[0]), 32'h1);
        checkOutput("rw_same_wready", 32'(W_ready[1]), 32'h1);
        tick();
        R_valid[0] = 1'b0;
        W_valid[1] = 1'b0;
        R_Addr[3*8 +: 8] = 8'h20;
        R_valid[3] = 1'b1;
        @(negedge clk);
        checkOutput("rw_next_rready", 32'(R_ready[3]), 32'h1);
        tick();
        R_valid[3] = 1'b0;
        @(negedge clk);
        checkOutput("rw_old_valid", 32'(R_out_valid[0]), 32'h1);
        checkOutput("rw_old_data", R_Data[0*32 +: 32], 32'h0000_0003);
        tick();
        @(negedge clk);
        checkOutput("rw_new_valid", 32'(R_out_valid[3]), 32'h1);
        checkOutput("rw_new_data", R_Data[3*32 +: 32], 32'h0000_0005);
        tick();
        repeat (2) tick();

        $display("[TB] init sweep");
        init_start = 1'b1;
        R_Addr[0*8 +: 8] = 8'h03;
        R_valid[0] = 1'b1;
        @(negedge clk);
        checkOutput("init_start_busy", 32'(busy), 32'h0);
        checkOutput("init_inflight_ready", 32'(R_ready[0]), 32'h1);
        tick();
        init_start = 1'b0;
        R_Addr  = {8'h13, 8'h22, 8'h31, 8'h40};
        R_valid = 4'b1111;
        W_Addr  = {8'h07, 8'h06, 8'h05, 8'h04};
        W_Data  = {4{32'h1234_0000}};
        W_valid = 4'b1111;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 10) init_start = 1'b1;
            if (i == 11) init_start = 1'b0;
            checkOutput($sformatf("init_busy_%0d", i), 32'(busy), 32'h1);
            checkOutput($sformatf("init_rready_%0d", i), 32'(R_ready), 32'h0);
            checkOutput($sformatf("init_wready_%0d", i), 32'(W_ready), 32'h0);
            tick();
        end
        R_valid = '0;
        W_valid = '0;
        @(negedge clk);
        checkOutput("init_done_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = INIT_VAL;
        tick();
        R_Addr[0*8 +: 8] = 8'h00;
        R_Addr[3*8 +: 8] = 8'hFF;
        R_valid = 4'b1001;
        @(negedge clk);
        checkOutput("post_init_ready", 32'(R_ready), 32'h9);
        tick();
        R_valid = '0;
        tick();
        @(negedge clk);
        checkOutput("post_init_lo", R_Data[0*32 +: 32], 32'hFFFF_FFFF);
        checkOutput("post_init_hi", R_Data[3*32 +: 32], 32'hFFFF_FFFF);
        tick();

        $display("[TB] reset with read in flight");
        writeOne(0, 8'h10, 32'h1234_5678);
        R_Addr[1*8 +: 8] = 8'h10;
        R_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_flight_ready", 32'(R_ready[1]), 32'h1);
        tick();
        R_valid[1] = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_no_valid_%0d", i), 32'(R_out_valid), 32'h0);
            tick();
        end
        R_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_reread_ready", 32'(R_ready[1]), 32'h1);
        tick();
        R_valid[1] = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("rst_reread_valid", 32'(R_out_valid[1]), 32'h1);
        checkOutput("rst_reread_data", R_Data[1*32 +: 32], 32'h1234_5678);
        tick();

        repeat (5) tick();
        for (int p = 0; p < PORT_NUM; p++) begin
            checkOutput($sformatf("drain_p%0d", p), 32'(exp_q[p].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
